// File: rtl/itlb_refill_walker.sv
// itlb_refill_walker: single-level page-table walker that refills the iTLB on a fetch miss,
// or raises a one-cycle page-fault strobe with a held cause and faulting VA.
module itlb_refill_walker #(
    parameter int PAGE_BITS   = 12,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vm_enable,
    input  logic [31:0] ptbr,
    input  logic        tlb_miss,
    input  logic [31:0] tlb_fault_addr,
    input  logic        flush,
    output logic        mem_read_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        itlb_write_en,
    output logic [31:0] itlb_write_va,
    output logic [31:0] itlb_write_pa,
    output logic        busy,
    output logic        page_fault,
    output logic [31:0] fault_va,
    output logic [1:0]  fault_cause
);
    typedef enum logic [2:0] {IDLE, REQ, WRITE, SETTLE, FAULT, HOLD} state_t;
    localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  count;
    logic        abort_q;
    logic [31:0] va;
    logic [1:0]  cause_next;
    logic        stop;
    logic        done;
    logic        unused_pte_bits;

    assign unused_pte_bits = ^{mem_rdata[PAGE_BITS-1:4], mem_rdata[2:1]};
    assign stop          = flush | ~vm_enable;
    assign mem_read_en   = state == REQ;
    assign itlb_write_en = state == WRITE;
    assign page_fault    = state == FAULT;
    assign busy          = state != IDLE;

    // A read ends on completion or on the last allowed wait cycle.
    assign done = mem_ready | (count == LAST);

    always_comb begin
        state_next = state;
        cause_next = 2'b00;
        case (state)
            IDLE:   state_next = (tlb_miss & vm_enable & ~flush) ? REQ : IDLE;
            REQ: begin
                cause_next = ~mem_ready   ? 2'b11 :
                             ~mem_rdata[0] ? 2'b01 :
                             ~mem_rdata[3] ? 2'b10 : 2'b00;
                if (done)
                    state_next = (abort_q | stop) ? IDLE : (cause_next != 2'b00) ? FAULT : WRITE;
            end
            WRITE:  state_next = stop ? IDLE : SETTLE;
            SETTLE: state_next = IDLE;
            FAULT:  state_next = stop ? IDLE : HOLD;
            HOLD:   state_next = (stop | ~tlb_miss | (tlb_fault_addr != va)) ? IDLE : HOLD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count         <= '0;
            abort_q       <= 1'b0;
            va            <= '0;
            mem_addr      <= '0;
            itlb_write_va <= '0;
            itlb_write_pa <= '0;
            fault_va      <= '0;
            fault_cause   <= '0;
        end else begin
            if (state == IDLE && state_next == REQ) begin
                va       <= tlb_fault_addr;
                count    <= '0;
                abort_q  <= 1'b0;
                mem_addr <= ptbr + 32'({tlb_fault_addr[31:PAGE_BITS], 2'b00});
            end
            if (state == REQ) begin
                count   <= count + 8'd1;
                abort_q <= abort_q | stop;
            end
            if (state == REQ && state_next == WRITE) begin
                itlb_write_va <= {va[31:PAGE_BITS], {PAGE_BITS{1'b0}}};
                itlb_write_pa <= {mem_rdata[31:PAGE_BITS], {PAGE_BITS{1'b0}}};
            end
            if (state == REQ && state_next == FAULT) begin
                fault_va    <= va;
                fault_cause <= cause_next;
            end
        end
    end
endmodule

// File: tb/tb_itlb_refill_walker.sv
// tb_itlb_refill_walker: directed and randomized walks checked against an outcome model
// computed from PTE flags, ready delay and flush position.
module tb_itlb_refill_walker;
    localparam int PB = 12;
    localparam int T  = 4;

    logic        clk = 1'b0;
    logic        reset, vm_enable, tlb_miss, flush, mem_ready;
    logic [31:0] ptbr, tlb_fault_addr, mem_rdata;
    logic        mem_read_en, itlb_write_en, busy, page_fault;
    logic [31:0] mem_addr, itlb_write_va, itlb_write_pa, fault_va;
    logic [1:0]  fault_cause;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    itlb_refill_walker #(.PAGE_BITS(PB), .MEM_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .vm_enable(vm_enable), .ptbr(ptbr),
        .tlb_miss(tlb_miss), .tlb_fault_addr(tlb_fault_addr), .flush(flush),
        .mem_read_en(mem_read_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .itlb_write_en(itlb_write_en),
        .itlb_write_va(itlb_write_va), .itlb_write_pa(itlb_write_pa),
        .busy(busy), .page_fault(page_fault), .fault_va(fault_va),
        .fault_cause(fault_cause)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd"}, mem_read_en, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wr"}, itlb_write_en, 0);
        chk({tag, "_wva"}, itlb_write_va, 0);
        chk({tag, "_wpa"}, itlb_write_pa, 0);
        chk({tag, "_pf"}, page_fault, 0);
        chk({tag, "_fva"}, fault_va, 0);
        chk({tag, "_fc"}, fault_cause, 0);
    endtask

    // delay: REQ cycles with mem_ready low before completion; flush_at: REQ cycle of a flush pulse (0 = none)
    task automatic walk(input logic [31:0] base, input logic [31:0] va, input logic [31:0] pte,
                        input int delay, input int flush_at);
        int          nreq     = (delay >= T) ? T : delay + 1;
        logic [1:0]  cause    = (delay >= T) ? 2'd3 : !pte[0] ? 2'd1 : !pte[3] ? 2'd2 : 2'd0;
        logic [31:0] exp_addr = base + ((va >> PB) << 2);
        ptbr = base; tlb_fault_addr = va; mem_rdata = pte;
        tlb_miss = 1'b1; mem_ready = 1'b0; flush = 1'b0;
        tick;
        for (int k = 1; k <= nreq; k++) begin
            mem_ready = (k > delay);
            flush = (k == flush_at);
            if (k == flush_at) tlb_miss = 1'b0;
            chk("req_rd", mem_read_en, 1);
            chk("req_addr", mem_addr, exp_addr);
            chk("req_busy", busy, 1);
            chk("req_nowr", itlb_write_en | page_fault, 0);
            tick;
        end
        flush = 1'b0; mem_ready = 1'b0;
        if (flush_at != 0) begin
            chk("abort_idle", busy, 0);
            chk("abort_nowr", itlb_write_en, 0);
            chk("abort_nopf", page_fault, 0);
        end else if (cause == 2'd0) begin
            chk("wr_en", itlb_write_en, 1);
            chk("wr_va", itlb_write_va, (va >> PB) << PB);
            chk("wr_pa", itlb_write_pa, (pte >> PB) << PB);
            chk("wr_nopf", page_fault, 0);
            tlb_miss = 1'b0;
            tick;
            chk("settle_busy", busy, 1);
            chk("settle_nowr", itlb_write_en, 0);
            tick;
            chk("wr_idle", busy, 0);
        end else begin
            chk("pf", page_fault, 1);
            chk("pf_cause", fault_cause, cause);
            chk("pf_va", fault_va, va);
            chk("pf_nowr", itlb_write_en, 0);
            tick;
            chk("hold_pf_off", page_fault, 0);
            chk("hold_busy", busy, 1);
            tick;
            chk("hold_no_rewalk", mem_read_en, 0);
            chk("hold_busy2", busy, 1);
            tlb_miss = 1'b0;
            tick;
            chk("hold_idle", busy, 0);
            chk("hold_fva", fault_va, va);
            chk("hold_cause", fault_cause, cause);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; vm_enable = 1'b1; tlb_miss = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        ptbr = '0; tlb_fault_addr = '0; mem_rdata = '0;
        #2;
        chk_all_zero("rst");
        #10 reset = 1'b0;

        walk(32'h0001_0000, 32'h0040_3ABC, 32'h0008_7009, 0, 0);
        walk(32'h0001_0000, 32'h0040_3ABC, 32'h0008_7008, 0, 0);
        walk(32'h0001_0000, 32'h0040_3ABC, 32'h0008_7001, 0, 0);
        walk(32'h0001_0000, 32'h0040_3ABC, 32'h0008_7009, 10, 0);
        walk(32'h0001_0000, 32'h0040_3ABC, 32'h0008_7009, 3, 2);
        walk(32'hFFFF_FFF0, 32'hFFFF_F123, 32'h1234_5009, 1, 0);

        vm_enable = 1'b0; tlb_miss = 1'b1; tlb_fault_addr = 32'h0000_5000;
        tick;
        chk("vm_off_ignored", busy, 0);
        tlb_miss = 1'b0; vm_enable = 1'b1;
        tick;

        // fault first so the captured fault registers are non-zero when reset hits
        walk(32'h0002_0000, 32'h7777_7000, 32'h0000_0000, 0, 0);
        tlb_miss = 1'b1; tlb_fault_addr = 32'h0123_4567; mem_ready = 1'b0;
        tick;
        tick;
        chk("pre_rst_busy", busy, 1);
        #2 reset = 1'b1;
        #1 chk_all_zero("async_rst");
        #1 reset = 1'b0; tlb_miss = 1'b0;
        walk(32'h0003_0000, 32'h0123_4567, 32'hABCD_E009, 2, 0);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] base = $urandom & 32'hFFFF_FFFC;
            logic [31:0] va   = $urandom;
            logic [31:0] pte  = $urandom;
            int          d    = $urandom_range(0, 5);
            int          n    = (d >= T) ? T : d + 1;
            int          f    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : 0;
            pte[0] = ($urandom_range(0, 3) != 0);
            pte[3] = ($urandom_range(0, 3) != 0);
            walk(base, va, pte, d, f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
